bus_region_arbiter: RTL and testbench
=====================================

Name: bus_region_arbiter

Overview:
- Parametrised successor to the fixed two-way CPU address split: decodes the CPU bus into up to NUM_REGIONS slave windows, each with its own base, mask and read latency.
- Registers the region select and read-data path, stalls the CPU through CPUEn for slow slaves, and returns DEFAULT_DATA on unmapped reads.
- Holds the CPU off for RESET_HOLD cycles after reset and while any slave requests a hold.
- Sits between CPUPWH1 and the memory / VGA / peripheral blocks.

Parameters:
- ADR_W, 16: address width.
- DATA_W, 8: data width.
- NUM_REGIONS, 2: slave window count, 1..4.
- REGION_BASE, {16'h2000,16'h0000}: packed ADR_W per region; region 0 is in the LSBs.
- REGION_MASK, {16'hE000,16'hE000}: packed ADR_W per region; hit_i = (AdrIn & MASK_i) == BASE_i.
- REGION_LAT, {2'd1,2'd1}: packed 2 bits per region; read latency 1..3 cycles; 0 is illegal and checked at elaboration.
- DEFAULT_DATA, 8'hFF: read data for unmapped addresses.
- RESET_HOLD, 16: CPUEn-low cycles after reset release, 0..255.

Ports:
- Clk  in  1  system clock (SysMainClk domain).
- Reset  in  1  synchronous, active-low.
- AdrIn  in  ADR_W  CPU address.
- DataIn  in  DATA_W  CPU write data.
- LdMem  in  1  CPU read request.
- WrtMem  in  1  CPU write request.
- DataOut  out  DATA_W  read data to CPU.
- CPUEn  out  1  CPU enable; low = stall.
- BusErr  out  1  sticky error flag.
- ErrClr  in  1  clears BusErr.
- SlvAdr  out  ADR_W  AdrIn passed through.
- SlvDataOut  out  DATA_W  DataIn passed through.
- SlvLd  out  NUM_REGIONS  one-hot read strobe.
- SlvWrt  out  NUM_REGIONS  one-hot write strobe.
- SlvDataIn  in  NUM_REGIONS*DATA_W  packed slave read data.
- SlvHold  in  NUM_REGIONS  slave requests CPU stall.

Behaviour:
- Reset (Reset=0 at a Clk edge):
  - State=IDLE, hold counter=RESET_HOLD.
  - BusErr=0, DataOut register=0, sel_q=0, miss_q=0.
  - SlvLd/SlvWrt are forced 0 combinationally while Reset=0.
  - CPUEn=0 while Reset=0.
  - Reset mid-read aborts with no data capture.
- Reset hold:
  - The counter decrements each cycle after release.
  - CPUEn=0 while counter≠0, so exactly RESET_HOLD low cycles.
  - No strobes are issued during hold.
- Decode:
  - Lowest-index hit wins on overlap.
  - No hit = miss.
- Definitions:
  - go = IDLE & counter==0 & ~|SlvHold.
  - stall = (state==WAIT) | counter≠0 | |SlvHold.
  - CPUEn = ~stall & Reset.
- Write:
  - SlvWrt[i] = go & WrtMem & hit_i, single cycle, no stall.
  - A write miss sets BusErr and has no other effect.
- Read:
  - SlvLd[i] = go & LdMem & ~WrtMem & hit_i.
  - On the strobe edge, latch sel_q=i and miss_q=miss, and load wait count = LAT_i−1.
  - LAT=1: stay IDLE. Data is valid in the next cycle, matching native BRAM timing.
  - LAT>1: enter WAIT with CPUEn=0 for LAT−1 cycles. The counter decrements each cycle; at 0, return to IDLE.
  - Result: the CPU sees data in the cycle after the last stall cycle.
- DataOut:
  - In the data-valid cycle (first IDLE cycle after the strobe or after WAIT), DataOut = miss_q ? DEFAULT_DATA : SlvDataIn[sel_q] combinationally, and the value is captured into the register.
  - All other cycles: DataOut = register (held).
- Read miss: DEFAULT_DATA is returned, BusErr is set, and there is no stall.
- LdMem & WrtMem together: the write wins, no SlvLd is issued, and BusErr is set.
- SlvHold:
  - A hold asserted in IDLE blocks new strobes.
  - A hold asserted during WAIT does not freeze the count but extends CPUEn=0 until it drops.
- BusErr:
  - Set by errors and cleared by ErrClr.
  - Set has priority over clear in the same cycle.
- Widths: all packed vectors are indexed [i*W +: W].

Test Plan:
1. Reset release with RESET_HOLD=16 → CPUEn=0 for exactly 16 cycles after Reset goes 1, then 1. No SlvLd/SlvWrt pulses occur during hold.
2. Write 8'h5A to 0x1234, then read it back from region 0 (LAT=1) → SlvWrt=2'b01 for one cycle. The read gives SlvLd=2'b01, DataOut=8'h5A in the next cycle, and CPUEn never drops.
3. Set region 1 LAT=3 and read 0x2000 with the slave driving 8'hC3 → SlvLd=2'b10 one cycle, CPUEn=0 for 2 cycles, then DataOut=8'hC3 and held afterwards.
4. Config BASE0=0x0000, BASE1=0x2000, masks 0xE000; read 0x4000 → no strobe, DataOut=8'hFF, BusErr=1. Pulse ErrClr → BusErr=0.
5. Assert LdMem and WrtMem together at 0x0010 → SlvWrt[0]=1, SlvLd=0, BusErr=1. Separately, assert SlvHold[1] for 5 cycles in IDLE → CPUEn=0 for those 5 cycles, with no strobes.
6. Assert Reset=0 during WAIT of a LAT=3 read → next cycle state is IDLE, strobes are 0, and DataOut=0. After release, CPUEn=0 for RESET_HOLD cycles again.

Source files
------------

// File: rtl/bus_region_arbiter.sv
// rtl/bus_region_arbiter.sv - CPU bus decoder into parametrised slave windows with per-region read latency
module bus_region_arbiter #(
  parameter int ADR_W       = 16,
  parameter int DATA_W      = 8,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADR_W-1:0] REGION_BASE = {16'h2000, 16'h0000},
  parameter logic [NUM_REGIONS*ADR_W-1:0] REGION_MASK = {16'hE000, 16'hE000},
  parameter logic [NUM_REGIONS*2-1:0]     REGION_LAT  = {2'd1, 2'd1},
  parameter logic [DATA_W-1:0]            DEFAULT_DATA = 8'hFF,
  parameter int RESET_HOLD  = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [ADR_W-1:0]              AdrIn,
  input  logic [DATA_W-1:0]             DataIn,
  input  logic                          LdMem,
  input  logic                          WrtMem,
  output logic [DATA_W-1:0]             DataOut,
  output logic                          CPUEn,
  output logic                          BusErr,
  input  logic                          ErrClr,
  output logic [ADR_W-1:0]              SlvAdr,
  output logic [DATA_W-1:0]             SlvDataOut,
  output logic [NUM_REGIONS-1:0]        SlvLd,
  output logic [NUM_REGIONS-1:0]        SlvWrt,
  input  logic [NUM_REGIONS*DATA_W-1:0] SlvDataIn,
  input  logic [NUM_REGIONS-1:0]        SlvHold
);

  localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  if (NUM_REGIONS < 1 || NUM_REGIONS > 4) begin : gCountChk
    $error("bus_region_arbiter: NUM_REGIONS must be 1..4");
  end
  if (RESET_HOLD < 0 || RESET_HOLD > 255) begin : gHoldChk
    $error("bus_region_arbiter: RESET_HOLD must be 0..255");
  end
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : gLatChk
    if (REGION_LAT[g*2 +: 2] == 2'd0) begin : gBad
      $error("bus_region_arbiter: REGION_LAT of 0 is illegal");
    end
  end

  typedef enum logic {IDLE, WAIT} arbStateT;

  arbStateT             state;
  logic [7:0]           holdCnt;
  logic [1:0]           waitCnt;
  logic [SEL_W-1:0]     selQ;
  logic                 missQ;
  logic                 validQ;
  logic [DATA_W-1:0]    dataQ;

  logic [NUM_REGIONS-1:0] hitVec;
  logic [NUM_REGIONS-1:0] winVec;
  logic                   anyHit;
  logic [SEL_W-1:0]       hitIdx;
  logic [1:0]             latSel;
  logic                   go;
  logic                   stall;
  logic                   wrAcc;
  logic                   rdAcc;
  logic                   errSet;
  logic [DATA_W-1:0]      rdData;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : gHit
    assign hitVec[g] = (AdrIn & REGION_MASK[g*ADR_W +: ADR_W]) == REGION_BASE[g*ADR_W +: ADR_W];
  end

  // Scan from the top down so the lowest-index hit is the one left standing.
  always_comb begin
    anyHit = 1'b0;
    hitIdx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hitVec[i]) begin
        anyHit = 1'b1;
        hitIdx = SEL_W'(i);
      end
    end
  end

  assign winVec = anyHit ? (NUM_REGIONS'(1) << hitIdx) : '0;
  assign latSel = REGION_LAT[hitIdx*2 +: 2];

  assign go     = Reset & (state == IDLE) & (holdCnt == 8'd0) & ~|SlvHold;
  assign stall  = (state == WAIT) | (holdCnt != 8'd0) | |SlvHold;
  assign CPUEn  = ~stall & Reset;

  assign wrAcc  = go & WrtMem;
  assign rdAcc  = go & LdMem & ~WrtMem;
  assign SlvWrt = wrAcc ? winVec : '0;
  assign SlvLd  = rdAcc ? winVec : '0;
  assign errSet = (wrAcc & ~anyHit) | (rdAcc & ~anyHit) | (go & LdMem & WrtMem);

  assign SlvAdr     = AdrIn;
  assign SlvDataOut = DataIn;

  assign rdData  = missQ ? DEFAULT_DATA : SlvDataIn[selQ*DATA_W +: DATA_W];
  assign DataOut = validQ ? rdData : dataQ;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      holdCnt <= 8'(RESET_HOLD);
      waitCnt <= 2'd0;
      selQ    <= '0;
      missQ   <= 1'b0;
      validQ  <= 1'b0;
      dataQ   <= '0;
      BusErr  <= 1'b0;
    end else begin
      if (holdCnt != 8'd0) holdCnt <= holdCnt - 8'd1;
      if (validQ) dataQ <= rdData;
      validQ <= 1'b0;
      if (errSet) BusErr <= 1'b1;
      else if (ErrClr) BusErr <= 1'b0;
      case (state)
        IDLE: begin
          if (rdAcc) begin
            selQ  <= hitIdx;
            missQ <= ~anyHit;
            if (anyHit && latSel > 2'd1) begin
              state   <= WAIT;
              waitCnt <= latSel - 2'd1;
            end else begin
              validQ <= 1'b1;
            end
          end
        end
        WAIT: begin
          // Slave holds only stretch CPUEn; the latency count always runs.
          waitCnt <= waitCnt - 2'd1;
          if (waitCnt == 2'd1) begin
            state  <= IDLE;
            validQ <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_region_arbiter.sv
// tb/tb_bus_region_arbiter.sv - randomized self-checking bench for bus_region_arbiter against a cycle-count model
module tb_bus_region_arbiter;

  logic        clk;
  logic        Reset;
  logic [15:0] AdrIn;
  logic [7:0]  DataIn;
  logic        LdMem;
  logic        WrtMem;
  logic [7:0]  DataOut;
  logic        CPUEn;
  logic        BusErr;
  logic        ErrClr;
  logic [15:0] SlvAdr;
  logic [7:0]  SlvDataOut;
  logic [1:0]  SlvLd;
  logic [1:0]  SlvWrt;
  logic [15:0] SlvDataIn;
  logic [1:0]  SlvHold;

  bus_region_arbiter #(
    .ADR_W(16), .DATA_W(8), .NUM_REGIONS(2),
    .REGION_BASE({16'h2000, 16'h0000}),
    .REGION_MASK({16'hE000, 16'hE000}),
    .REGION_LAT({2'd3, 2'd1}),
    .DEFAULT_DATA(8'hFF),
    .RESET_HOLD(16)
  ) dut (
    .Clk(clk), .Reset(Reset), .AdrIn(AdrIn), .DataIn(DataIn),
    .LdMem(LdMem), .WrtMem(WrtMem), .DataOut(DataOut), .CPUEn(CPUEn),
    .BusErr(BusErr), .ErrClr(ErrClr), .SlvAdr(SlvAdr), .SlvDataOut(SlvDataOut),
    .SlvLd(SlvLd), .SlvWrt(SlvWrt), .SlvDataIn(SlvDataIn), .SlvHold(SlvHold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  // Reference: windows and latencies as plain tables, timing as cycle numbers.
  int baseTab[2] = '{16'h0000, 16'h2000};
  int maskTab[2] = '{16'hE000, 16'hE000};
  int latTab[2]  = '{1, 3};

  logic [7:0] slvData[2];
  int   cyc, holdLeft, waitLeft, dueCycle, dueRegion;
  logic dueMiss, expErr;
  logic [7:0] lastData;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int regionOf(input logic [15:0] adr);
    for (int i = 0; i < 2; i++)
      if ((int'(adr) & maskTab[i]) == baseTab[i]) return i;
    return -1;
  endfunction

  task automatic step(input logic rst, input logic [15:0] adr, input logic [7:0] din,
                      input logic ld, input logic wr, input logic clr, input logic [1:0] hold);
    int r, lat;
    logic en;
    logic [1:0] expLd, expWr;
    logic [7:0] expD;
    @(negedge clk);
    Reset = rst; AdrIn = adr; DataIn = din; LdMem = ld; WrtMem = wr;
    ErrClr = clr; SlvHold = hold; SlvDataIn = {slvData[1], slvData[0]};
    #1;
    r  = regionOf(adr);
    en = rst && holdLeft == 0 && waitLeft == 0 && hold == 2'b00;
    expWr = (en && wr && r >= 0) ? 2'(1 << r) : 2'b00;
    expLd = (en && ld && !wr && r >= 0) ? 2'(1 << r) : 2'b00;
    expD  = (cyc == dueCycle) ? (dueMiss ? 8'hFF : slvData[dueRegion]) : lastData;
    checkVal("CPUEn", 32'(CPUEn), 32'(en));
    checkVal("SlvWrt", 32'(SlvWrt), 32'(expWr));
    checkVal("SlvLd", 32'(SlvLd), 32'(expLd));
    checkVal("DataOut", 32'(DataOut), 32'(expD));
    checkVal("BusErr", 32'(BusErr), 32'(expErr));
    checkVal("SlvAdr", 32'(SlvAdr), 32'(adr));
    checkVal("SlvDataOut", 32'(SlvDataOut), 32'(din));
    lastData = expD;
    if (!rst) begin
      holdLeft = 16; waitLeft = 0; dueCycle = -1; lastData = 8'h00; expErr = 1'b0;
    end else begin
      if (en && ((wr && r < 0) || (ld && !wr && r < 0) || (ld && wr))) expErr = 1'b1;
      else if (clr) expErr = 1'b0;
      if (holdLeft > 0) holdLeft--;
      if (waitLeft > 0) waitLeft--;
      if (en && ld && !wr) begin
        lat       = (r < 0) ? 1 : latTab[r];
        waitLeft  = lat - 1;
        dueCycle  = cyc + lat;
        dueRegion = (r < 0) ? 0 : r;
        dueMiss   = (r < 0);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 16'h0100, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  int lowCnt;
  logic [15:0] rAdr;

  initial begin
    Reset = 1'b0; AdrIn = '0; DataIn = '0; LdMem = 1'b0; WrtMem = 1'b0;
    ErrClr = 1'b0; SlvHold = '0; SlvDataIn = '0;
    slvData[0] = 8'h00; slvData[1] = 8'h00;
    repeat (2) @(negedge clk);
    cyc = 0; holdLeft = 16; waitLeft = 0; dueCycle = -1; dueRegion = 0;
    dueMiss = 1'b0; expErr = 1'b0; lastData = 8'h00;
    step(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);

    // Reset hold length
    lowCnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
      if (!CPUEn) lowCnt++;
    end
    checkVal("holdLen", 32'(lowCnt), 32'd16);

    // Write then LAT=1 read in region 0
    step(1'b1, 16'h1234, 8'h5A, 1'b0, 1'b1, 1'b0, 2'b00);
    slvData[0] = 8'h5A;
    step(1'b1, 16'h1234, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00);
    idle(2);

    // LAT=3 read in region 1, result held after slave data changes
    slvData[1] = 8'hC3;
    step(1'b1, 16'h2000, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00);
    idle(3);
    slvData[1] = 8'h00;
    idle(2);
    checkVal("lat3Held", 32'(DataOut), 32'hC3);

    // Unmapped read, then clear
    step(1'b1, 16'h4000, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00);
    idle(1);
    checkVal("missData", 32'(DataOut), 32'hFF);
    step(1'b1, 16'h0100, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00);
    idle(1);

    // Read and write together, then slave hold in IDLE
    step(1'b1, 16'h0010, 8'h77, 1'b1, 1'b1, 1'b0, 2'b00);
    step(1'b1, 16'h0100, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0010, 8'h11, 1'b1, 1'b1, 1'b0, 2'b10);
    idle(1);

    // Reset in the middle of a LAT=3 read
    slvData[1] = 8'h99;
    step(1'b1, 16'h2004, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00);
    idle(1);
    step(1'b0, 16'h2004, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00);
    lowCnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'h0100, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
      if (!CPUEn) lowCnt++;
    end
    checkVal("holdLen2", 32'(lowCnt), 32'd16);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      slvData[0] = 8'($urandom);
      slvData[1] = 8'($urandom);
      case ($urandom_range(2, 0))
        0: rAdr = 16'($urandom_range(16'h1FFF, 0));
        1: rAdr = 16'h2000 + 16'($urandom_range(16'h1FFF, 0));
        default: rAdr = 16'h4000 + 16'($urandom_range(16'hBFFF, 0));
      endcase
      step(($urandom_range(299, 0) != 0), rAdr, 8'($urandom),
           ($urandom_range(1, 0) == 1), ($urandom_range(3, 0) == 0),
           ($urandom_range(7, 0) == 0),
           ($urandom_range(9, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", nChecks, nFail);
    $finish;
  end

endmodule
